multicycle_ctrl: RTL and testbench

- Parametrised multicycle control unit that replaces hand-driven control sequences on the Instruction_FD datapath.
- Decodes the RV64 subset ld, sd, add, sub, addi, beq and bne.
- Sequences fetch, decode, execute, memory, writeback and PC-update states.
- Drives WE_mem, WE_reg, OP_MEM_I, ADD_SUB, PC_load, IR_load and select_flags.
- Memory latency is parametrised through a wait counter.

---
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Moore-style multicycle control unit for the Instruction_FD datapath.
//   Decodes the RV64 subset ld, sd, add, sub, addi, beq, bne and sequences
//   FETCH -> DECODE -> {EXEC | MEM [-> WB]} -> PCUPD.
//   Memory accesses (fetch, load, store) take MEM_LAT cycles, timed by a
//   small wait counter. Illegal encodings park the FSM in HALT until reset.
//
// Parameters
//   INSTR_W  instruction width (>= 32, only [31:0] decoded)
//   MEM_LAT  cycles per memory access (>= 1)
//   CNT_W    width of the retired-instruction counter
//
// Ports
//   clk           clock, rising edge
//   reset         synchronous, active-low
//   run           start/continue; sampled in IDLE and PCUPD
//   instr         IR contents, valid from DECODE onward
//   WE_mem        data-memory write enable
//   WE_reg        register-bank write enable
//   OP_MEM_I      ALU operand-B select (0 reg, 1 ld/sd offs, 2 I-imm, 3 br offs)
//   ADD_SUB       ALU op (0 add, 1 sub)
//   PC_load       PC register load
//   IR_load       IR register load
//   select_flags  PC source (000 PC+4, 001 br if zero, 010 br if not zero)
//   halted        illegal instruction trapped
//   retired       retired-instruction count
//
// Optional feature
//   MULTICYCLE_CTRL_RETIRED_CNT_EN  when defined, retired counts PCUPD cycles
//                                   (wrapping); otherwise retired is tied to 0.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int INSTR_W = 32,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  output logic               WE_mem,
  output logic               WE_reg,
  output logic [1:0]         OP_MEM_I,
  output logic               ADD_SUB,
  output logic               PC_load,
  output logic               IR_load,
  output logic [2:0]         select_flags,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  localparam int CW = $clog2(MEM_LAT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_LD, C_SD, C_ADD, C_SUB, C_ADDI, C_BEQ, C_BNE
  } cls_t;

  state_t        state, state_nx;
  cls_t          cls, cls_dec;
  logic [CW-1:0] cnt;
  logic          cnt_last;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7_b30;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign f7_b30   = instr[30];
  assign cnt_last = (cnt == CW'(MEM_LAT - 1));

  // Fields the subset never looks at.
  logic unused_lo;
  assign unused_lo = ^{instr[31], instr[29:15], instr[11:7]};
  generate
    if (INSTR_W > 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^instr[INSTR_W-1:32];
    end
  endgenerate

  // Instruction class decode, consumed only in DECODE.
  always_comb begin
    cls_dec = C_NONE;
    case (opcode)
      7'b0000011: if (funct3 == 3'b011) cls_dec = C_LD;
      7'b0100011: if (funct3 == 3'b011) cls_dec = C_SD;
      7'b0110011: if (funct3 == 3'b000) cls_dec = f7_b30 ? C_SUB : C_ADD;
      7'b0010011: if (funct3 == 3'b000) cls_dec = C_ADDI;
      7'b1100011: begin
        if (funct3 == 3'b000) cls_dec = C_BEQ;
        else if (funct3 == 3'b001) cls_dec = C_BNE;
      end
      default: cls_dec = C_NONE;
    endcase
  end

  // State register, latched class and wait counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cls   <= C_NONE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) cls <= cls_dec;
      // Any state change restarts the count, so FETCH and MEM always
      // begin at 0; the counter saturates at the last count.
      if (state_nx != state) cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && !cnt_last)
        cnt <= cnt + CW'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (run) state_nx = S_FETCH;
      S_FETCH:  if (cnt_last) state_nx = S_DECODE;
      S_DECODE: begin
        case (cls_dec)
          C_LD, C_SD:           state_nx = S_MEM;
          C_ADD, C_SUB, C_ADDI: state_nx = S_EXEC;
          C_BEQ, C_BNE:         state_nx = S_PCUPD;
          default:              state_nx = S_HALT;
        endcase
      end
      S_EXEC:   state_nx = S_PCUPD;
      S_MEM:    if (cnt_last) state_nx = (cls == C_LD) ? S_WB : S_PCUPD;
      S_WB:     state_nx = S_PCUPD;
      S_PCUPD:  state_nx = run ? S_FETCH : S_IDLE;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Moore outputs: state, latched class and wait count only.
  always_comb begin
    WE_mem       = 1'b0;
    WE_reg       = 1'b0;
    OP_MEM_I     = 2'd0;
    ADD_SUB      = 1'b0;
    PC_load      = 1'b0;
    IR_load      = 1'b0;
    select_flags = 3'b000;
    halted       = 1'b0;
    case (state)
      S_FETCH: IR_load = cnt_last;
      S_EXEC: begin
        WE_reg   = 1'b1;
        OP_MEM_I = (cls == C_ADDI) ? 2'd2 : 2'd0;
        ADD_SUB  = (cls == C_SUB);
      end
      S_MEM: begin
        OP_MEM_I = 2'd1;
        WE_mem   = (cls == C_SD) && cnt_last;
      end
      S_WB: begin
        OP_MEM_I = 2'd1;
        WE_reg   = 1'b1;
      end
      S_PCUPD: begin
        PC_load = 1'b1;
        if (cls == C_BEQ || cls == C_BNE) begin
          OP_MEM_I     = 2'd3;
          ADD_SUB      = 1'b1;
          select_flags = (cls == C_BEQ) ? 3'b001 : 3'b010;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

`ifdef MULTICYCLE_CTRL_RETIRED_CNT_EN
  // One retirement per PCUPD; HALT never reaches PCUPD so the count holds.
  always_ff @(posedge clk) begin
    if (!reset)                retired <= '0;
    else if (state == S_PCUPD) retired <= retired + CNT_W'(1);
  end
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Two instances (MEM_LAT=1 with a 4-bit retired counter, MEM_LAT=3 with a
//   32-bit one), each driven independently. Expected per-cycle output vectors
//   come from a phase-level model: fetch phase, decode, class-specific
//   execute/memory phases, PC update, derived from instruction class and
//   memory latency. Directed test-plan cases plus random instruction streams.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int C_ILL = 0, C_LD = 1, C_SD = 2, C_ADD = 3, C_SUB = 4,
                 C_ADDI = 5, C_BEQ = 6, C_BNE = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n, run, we_mem, we_reg, add_sub, pc_load, ir_load, halted;
  logic [1:0][1:0] op_mem;
  logic [1:0][2:0] sel;
  logic [31:0]     instr [2];
  logic [3:0]      ret_a;
  logic [31:0]     ret_b;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ret_m [2];
  logic [10:0] expq [$];

  multicycle_ctrl #(.INSTR_W(32), .MEM_LAT(1), .CNT_W(4)) u_dut_l1 (
    .clk(clk), .reset(rst_n[0]), .run(run[0]), .instr(instr[0]),
    .WE_mem(we_mem[0]), .WE_reg(we_reg[0]), .OP_MEM_I(op_mem[0]),
    .ADD_SUB(add_sub[0]), .PC_load(pc_load[0]), .IR_load(ir_load[0]),
    .select_flags(sel[0]), .halted(halted[0]), .retired(ret_a));

  multicycle_ctrl #(.INSTR_W(32), .MEM_LAT(3), .CNT_W(32)) u_dut_l3 (
    .clk(clk), .reset(rst_n[1]), .run(run[1]), .instr(instr[1]),
    .WE_mem(we_mem[1]), .WE_reg(we_reg[1]), .OP_MEM_I(op_mem[1]),
    .ADD_SUB(add_sub[1]), .PC_load(pc_load[1]), .IR_load(ir_load[1]),
    .select_flags(sel[1]), .halted(halted[1]), .retired(ret_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // {WE_mem, WE_reg, OP_MEM_I, ADD_SUB, PC_load, IR_load, select_flags, halted}
  function automatic logic [10:0] get_out(input int d);
    return {we_mem[d], we_reg[d], op_mem[d], add_sub[d], pc_load[d],
            ir_load[d], sel[d], halted[d]};
  endfunction

  function automatic logic [10:0] ov(input bit wm, input bit wr, input logic [1:0] op,
                                     input bit as, input bit pl, input bit il,
                                     input logic [2:0] sf, input bit h);
    return {wm, wr, op, as, pl, il, sf, h};
  endfunction

  function automatic logic [31:0] get_ret(input int d);
    return (d == 0) ? {28'd0, ret_a} : ret_b;
  endfunction

  function automatic logic [31:0] exp_ret(input int d);
`ifdef MULTICYCLE_CTRL_RETIRED_CNT_EN
    return ret_m[d];
`else
    return (d < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic bump_ret(input int d);
    if (d == 0) ret_m[0] = (ret_m[0] + 32'd1) & 32'hF;
    else        ret_m[1] = ret_m[1] + 32'd1;
  endtask

  // Phase-level reference: the whole output trace of one instruction.
  task automatic build(input int d, input int cls);
    int l;
    l = lat(d);
    expq.delete();
    for (int i = 0; i < l; i++) expq.push_back(ov(0, 0, 0, 0, 0, i == l - 1, 0, 0));
    expq.push_back(11'd0);                                   // decode
    case (cls)
      C_ADD, C_SUB: expq.push_back(ov(0, 1, 0, cls == C_SUB, 0, 0, 0, 0));
      C_ADDI:       expq.push_back(ov(0, 1, 2, 0, 0, 0, 0, 0));
      C_LD: begin
        for (int i = 0; i < l; i++) expq.push_back(ov(0, 0, 1, 0, 0, 0, 0, 0));
        expq.push_back(ov(0, 1, 1, 0, 0, 0, 0, 0));
      end
      C_SD:
        for (int i = 0; i < l; i++) expq.push_back(ov(i == l - 1, 0, 1, 0, 0, 0, 0, 0));
      default: ;
    endcase
    case (cls)
      C_BEQ:   expq.push_back(ov(0, 0, 3, 1, 1, 0, 3'b001, 0));
      C_BNE:   expq.push_back(ov(0, 0, 3, 1, 1, 0, 3'b010, 0));
      C_ILL:   for (int i = 0; i < 20; i++) expq.push_back(ov(0, 0, 0, 0, 0, 0, 0, 1));
      default: expq.push_back(ov(0, 0, 0, 0, 1, 0, 0, 0));
    endcase
  endtask

  function automatic logic [31:0] mk_instr(input int cls);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    imm = 12'($urandom);
    case (cls)
      C_LD:    return {imm, rs1, 3'b011, rd, 7'b0000011};
      C_SD:    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      C_ADD:   return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      C_SUB:   return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      C_ADDI:  return {imm, rs1, 3'b000, rd, 7'b0010011};
      C_BEQ:   return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
      default: return {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b1100011};
    endcase
  endfunction

  // Called at a negedge with the FSM in IDLE or PCUPD; runs one instruction.
  task automatic do_instr(input int d, input logic [31:0] ins, input int cls,
                          input bit keep, input string tag);
    build(d, cls);
    instr[d] = ins;
    run[d]   = 1'b1;
    for (int i = 0; i < expq.size(); i++) begin
      @(negedge clk);
      chk(tag, 32'(get_out(d)), 32'(expq[i]));
      if (i == 0) begin
        chk("retired", get_ret(d), exp_ret(d));
        run[d] = keep;
      end
    end
    bump_ret(d);
    if (!keep) begin
      @(negedge clk);
      chk("idle_after", 32'(get_out(d)), 32'd0);
      chk("retired_idle", get_ret(d), exp_ret(d));
    end
  endtask

  task automatic rand_test(input int d, input int n);
    int  cls;
    bit  keep;
    for (int k = 0; k < n; k++) begin
      cls  = int'($urandom_range(1, 7));
      keep = ($urandom_range(0, 3) != 0) && (k != n - 1);
      do_instr(d, mk_instr(cls), cls, keep, "rand");
    end
  endtask

  task automatic halt_test(input int d);
    build(d, C_ILL);
    instr[d] = 32'hFFFF_FFFF;
    run[d]   = 1'b1;
    for (int i = 0; i < expq.size(); i++) begin
      @(negedge clk);
      chk("halt_seq", 32'(get_out(d)), 32'(expq[i]));
    end
    chk("halt_retired_hold", get_ret(d), exp_ret(d));
    rst_n[d] = 1'b0;
    @(negedge clk);
    chk("halt_reset_out", 32'(get_out(d)), 32'd0);
    ret_m[d] = 32'd0;
    chk("halt_reset_retired", get_ret(d), exp_ret(d));
    rst_n[d] = 1'b1;
    run[d]   = 1'b0;
    @(negedge clk);
    chk("halt_reset_idle", 32'(get_out(d)), 32'd0);
  endtask

  // Reset while a load waits on memory: no writeback may follow.
  task automatic reset_mid_load(input int d);
    build(d, C_LD);
    instr[d] = 32'h0030_3183;
    run[d]   = 1'b1;
    for (int i = 0; i < lat(d) + 3; i++) begin
      @(negedge clk);
      chk("rst_ld_pre", 32'(get_out(d)), 32'(expq[i]));
    end
    rst_n[d] = 1'b0;
    run[d]   = 1'b0;
    @(negedge clk);
    chk("rst_ld_out", 32'(get_out(d)), 32'd0);
    rst_n[d] = 1'b1;
    ret_m[d] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_ld_quiet", 32'(get_out(d)), 32'd0);
    end
    chk("rst_ld_retired", get_ret(d), exp_ret(d));
  endtask

  initial begin
    rst_n    = 2'b00;
    run      = 2'b00;
    instr[0] = 32'd0;
    instr[1] = 32'd0;
    ret_m[0] = 32'd0;
    ret_m[1] = 32'd0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_out", 32'(get_out(d)), 32'd0);
      chk("reset_retired", get_ret(d), 32'd0);
    end
    rst_n = 2'b11;

    // MEM_LAT = 1
    do_instr(0, 32'h0010_3083, C_LD,  1, "ld_l1");
    do_instr(0, 32'h0020_81B3, C_ADD, 1, "add_l1");
    do_instr(0, 32'h4011_8233, C_SUB, 0, "sub_l1");
    do_instr(0, 32'h0031_8463, C_BEQ, 0, "beq_l1");
    do_instr(0, 32'h0031_9463, C_BNE, 1, "bne_l1");
    rand_test(0, 40);
    halt_test(0);

    // MEM_LAT = 3
    do_instr(1, 32'h0030_3183, C_LD, 1, "ld_l3");
    do_instr(1, 32'h0030_3223, C_SD, 0, "sd_l3");
    do_instr(1, 32'h0031_8463, C_BEQ, 1, "beq_l3");
    do_instr(1, 32'h0031_9463, C_BNE, 0, "bne_l3");
    rand_test(1, 40);
    reset_mid_load(1);
    halt_test(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
